// File: rtl/vec_normalize_unit_pkg.sv
// Shared definitions for the vector-normalize block: FSM state encoding,
// FP16 constants and default vector geometry.
package vec_normalize_unit_pkg;

  localparam int N_ELEM_DEF = 32;
  localparam int W_DEF      = 16;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_HALF = 16'h3800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SCALE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/vec_normalize_unit_fp16_mult.sv
// fp16_mult: combinational IEEE binary16 multiply, round-to-nearest-even.
//   a_i, b_i : FP16 operands
//   p_o      : FP16 product
// Subnormal operands are treated as zero and results below the normal range
// flush to signed zero; overflow saturates to signed infinity. NaN operands are
// passed through unchanged, Inf keeps its magnitude (Inf * 0 gives a quiet NaN).
module fp16_mult
  import vec_normalize_unit_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] p_o
);

  logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        norm, guard, sticky, rnd;
  logic [21:0] prod;
  logic [9:0]  frac;
  logic [10:0] mant_r;
  logic [7:0]  ea_x, eb_x;
  logic signed [7:0] exp_s;

  always_comb begin
    sgn    = a_i[15] ^ b_i[15];
    a_nan  = (a_i[14:10] == 5'h1F) && (a_i[9:0] != 10'h0);
    b_nan  = (b_i[14:10] == 5'h1F) && (b_i[9:0] != 10'h0);
    a_inf  = (a_i[14:10] == 5'h1F) && (a_i[9:0] == 10'h0);
    b_inf  = (b_i[14:10] == 5'h1F) && (b_i[9:0] == 10'h0);
    a_zero = (a_i[14:10] == 5'h00);
    b_zero = (b_i[14:10] == 5'h00);

    prod = {11'h0, 1'b1, a_i[9:0]} * {11'h0, 1'b1, b_i[9:0]};
    // product of two 1.f mantissas lies in [1,4); bit 21 flags the [2,4) case
    norm = prod[21];
    if (norm) begin
      frac   = prod[20:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      frac   = prod[19:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    rnd    = guard & (sticky | frac[0]);
    mant_r = {1'b0, frac} + {10'h0, rnd};

    ea_x  = {3'b0, a_i[14:10]};
    eb_x  = {3'b0, b_i[14:10]};
    // mantissa rounding carry (mant_r[10]) bumps the exponent; fraction is then 0
    exp_s = $signed(ea_x) + $signed(eb_x) - 8'sd15
          + $signed({7'b0, norm}) + $signed({7'b0, mant_r[10]});

    p_o = {sgn, exp_s[4:0], mant_r[9:0]};
    if (exp_s >= 8'sd31)     p_o = {sgn, 5'h1F, 10'h0};
    else if (exp_s <= 8'sd0) p_o = {sgn, 15'h0};

    if (a_zero || b_zero)    p_o = {sgn, FP16_ZERO[14:0]};
    if (a_inf || b_inf)      p_o = (a_zero || b_zero) ? 16'h7E00 : {sgn, 5'h1F, 10'h0};
    if (b_nan)               p_o = b_i;
    if (a_nan)               p_o = a_i;
  end

endmodule

// File: rtl/vec_normalize_unit.sv
// vec_normalize_unit: captures one N_ELEM x FP16 vector, requests 1/||v|| from
// the inverse-magnitude unit (start/done), then scales each element through a
// single shared fp16_mult, one element per cycle, and presents the unit-norm
// vector downstream with a valid/ready handshake.
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      input vector handshake, in_vec_flat element i at [i*W +: W]
//   imu_start/imu_vec_flat start pulse and held vector to inverse-magnitude unit
//   imu_mag_inv/imu_done   result and its one-cycle done strobe
//   out_valid/out_ready    output handshake, out_vec_flat normalized vector
//   out_zero               qualifies out_valid: input magnitude was zero
//   err_timeout            sticky, done not seen within TIMEOUT cycles (0 disables)
module vec_normalize_unit
  import vec_normalize_unit_pkg::*;
#(
  parameter int N_ELEM  = N_ELEM_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_ELEM*W-1:0] in_vec_flat,
  output logic                imu_start,
  output logic [N_ELEM*W-1:0] imu_vec_flat,
  input  logic [W-1:0]        imu_mag_inv,
  input  logic                imu_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_ELEM*W-1:0] out_vec_flat,
  output logic                out_zero,
  output logic                err_timeout
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int TW    = 8;  // TIMEOUT is limited to 255

  state_e                     state_q;
  logic [N_ELEM-1:0][W-1:0]   vec_q, out_q;
  logic [W-1:0]               mag_q;
  logic [IDX_W-1:0]           idx_q;
  logic [TW-1:0]              timer_q;
  logic                       in_ready_q, imu_start_q, out_valid_q, out_zero_q, err_q;
  logic [W-1:0]               prod_d, elem_d;
  logic                       mag_zero_d;

  fp16_mult u_mul (
    .a_i (vec_q[idx_q]),
    .b_i (mag_q),
    .p_o (prod_d)
  );

  // zero magnitude means an all-zero input: force +0 rather than trust 0*x
  assign mag_zero_d = (mag_q == FP16_ZERO);
  assign elem_d     = mag_zero_d ? FP16_ZERO : prod_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      out_q       <= '0;
      mag_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      in_ready_q  <= 1'b0;
      imu_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      imu_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            vec_q       <= in_vec_flat;
            in_ready_q  <= 1'b0;
            imu_start_q <= 1'b1;  // visible exactly during REQ
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          timer_q <= TW'(1);      // timer reads k during the k-th WAIT cycle
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imu_done) begin
            mag_q   <= imu_mag_inv;
            idx_q   <= '0;
            state_q <= ST_SCALE;
          end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT)) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_SCALE: begin
          out_q[idx_q] <= elem_d;
          out_zero_q   <= mag_zero_d;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign imu_start    = imu_start_q;
  assign imu_vec_flat = vec_q;
  assign out_valid    = out_valid_q;
  assign out_vec_flat = out_q;
  assign out_zero     = out_zero_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_vec_normalize_unit.sv
module tb_vec_normalize_unit;
  localparam int N  = 32;
  localparam int W  = 16;
  localparam int TO = 8;
  localparam int VW = N * W;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, imu_done = 1'b0;
  logic          in_ready, imu_start, out_valid, out_zero, err_timeout;
  logic [VW-1:0] in_vec_flat = '0, imu_vec_flat, out_vec_flat;
  logic [W-1:0]  imu_mag_inv = '0;

  int            n_chk = 0, n_err = 0, start_cnt = 0, acc_cnt = 0;
  logic          resp_en = 1'b1;
  int            resp_d = 5;
  logic [15:0]   resp_mag = 16'h3800;
  logic [VW-1:0] cur_vec = '0;

  vec_normalize_unit #(.N_ELEM(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec_flat(in_vec_flat),
    .imu_start(imu_start), .imu_vec_flat(imu_vec_flat),
    .imu_mag_inv(imu_mag_inv), .imu_done(imu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec_flat(out_vec_flat),
    .out_zero(out_zero), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference arithmetic: exact reals, then round-to-nearest-even to FP16
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = real'(1024 + int'(h[9:0])) / 1024.0;
    e = int'(h[14:10]);
    for (int k = 15; k < e; k++) m = m * 2.0;
    for (int k = e; k < 15; k++) m = m / 2.0;
    return m;
  endfunction

  function automatic logic [15:0] r2h(input real xin);
    real x, m, fr;
    int  e, mi, eb;
    x = xin; e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    m  = x * 1024.0;
    mi = int'($floor(m));
    fr = m - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 2048) begin mi = 1024; e++; end
    eb = e + 15;
    if (eb >= 31) return 16'h7C00;
    if (eb <= 0)  return 16'h0000;
    return {1'b0, 5'(eb), 10'(mi - 1024)};
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {a[15] ^ b[15], 15'h0};
    r = r2h(h2r(a) * h2r(b));
    return {a[15] ^ b[15], r[14:0]};
  endfunction

  function automatic logic [15:0] rnd_elem();
    if ($urandom_range(0, 15) == 0) return 16'h0000;
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom_range(0, 1023))};
  endfunction

  // ---- behavioural inverse-magnitude responder: done D cycles after the REQ cycle
  initial forever begin
    @(posedge clk);
    if (imu_start === 1'b1 && resp_en) begin
      repeat (resp_d) @(posedge clk);
      #1 imu_done = 1'b1; imu_mag_inv = resp_mag;
      chk("imu_vec_stable", imu_vec_flat, cur_vec);
      @(posedge clk);
      #1 imu_done = 1'b0;
    end
  end

  always @(negedge clk) if (imu_start === 1'b1) start_cnt++;

  task automatic accept(input logic [VW-1:0] v);
    int   n;
    logic ok;
    n = 0; ok = 1'b0;
    in_vec_flat = v; in_valid = 1'b1; cur_vec = v;
    while (!ok && n < 50) begin
      @(posedge clk);
      ok = in_ready;
      n++;
    end
    chk("accept", VW'(ok), VW'(1));
    if (ok) acc_cnt++;
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vec(input logic [VW-1:0] v, input logic [15:0] mag, input int d, input int stall);
    logic [VW-1:0] exp_v;
    int            n;
    logic          got;
    resp_mag = mag; resp_d = d; resp_en = 1'b1;
    for (int i = 0; i < N; i++)
      exp_v[i*W +: W] = (mag == 16'h0) ? 16'h0 : ref_mul(v[i*W +: W], mag);
    accept(v);
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      got = out_valid;
    end
    chk("latency", VW'(n), VW'(d + N + 2));
    chk("start_pulses", VW'(start_cnt), VW'(acc_cnt));
    chk("out_vec", out_vec_flat, exp_v);
    chk("out_zero", VW'(out_zero), VW'(mag == 16'h0));
    for (int k = 0; k < stall; k++) begin
      in_vec_flat = ~v;
      in_valid    = (k % 2 == 0);
      @(posedge clk); #1;
      chk("hold_valid", VW'(out_valid), VW'(1));
      chk("hold_vec", out_vec_flat, exp_v);
      chk("hold_in_ready", VW'(in_ready), VW'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("out_valid_drop", VW'(out_valid), VW'(0));
    chk("idle_in_ready", VW'(in_ready), VW'(1));
  endtask

  initial begin
    logic [VW-1:0] v;
    int            n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_imu_start", VW'(imu_start), VW'(0));
    chk("rst_err", VW'(err_timeout), VW'(0));
    chk("rst_out_vec", out_vec_flat, '0);
    chk("rst_imu_vec", imu_vec_flat, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", VW'(in_ready), VW'(1));

    // 1: all 2.0, mag 0.5, D=5 -> all 1.0
    for (int i = 0; i < N; i++) v[i*W +: W] = 16'h4000;
    run_vec(v, 16'h3800, 5, 0);
    chk("t1_elem0", VW'(out_vec_flat[15:0]), VW'(16'h3C00));

    // 2: alternating -4/+4, mag 0.25
    for (int i = 0; i < N; i++) v[i*W +: W] = (i % 2 == 0) ? 16'hC400 : 16'h4400;
    run_vec(v, 16'h3400, 3, 0);
    chk("t2_elem0", VW'(out_vec_flat[15:0]), VW'(16'hBC00));
    chk("t2_elem1", VW'(out_vec_flat[31:16]), VW'(16'h3C00));

    // 3: zero vector then a normal one
    run_vec('0, 16'h0000, 2, 0);
    for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
    run_vec(v, 16'h3A00, 4, 0);

    // 4: output stall 10 cycles with ignored in_valid pulses
    for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
    run_vec(v, 16'h3555, 1, 10);

    // randomized vectors
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
      run_vec(v, {1'b0, 5'($urandom_range(12, 16)), 10'($urandom_range(0, 1023))},
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
    end

    // 5: no done -> timeout at WAIT cycle TO
    resp_en = 1'b0;
    for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
    accept(v);
    repeat (TO) @(posedge clk);
    #1 chk("err_before_to", VW'(err_timeout), VW'(0));
    @(posedge clk); #1;
    chk("err_at_to", VW'(err_timeout), VW'(1));
    chk("to_in_ready", VW'(in_ready), VW'(1));
    chk("to_no_out", VW'(out_valid), VW'(0));
    resp_en = 1'b1;

    // 6: reset during SCALE at idx 12
    for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
    resp_mag = 16'h3800; resp_d = 3;
    accept(v);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!imu_done && n < 50);
    chk("t6_done_seen", VW'(imu_done), VW'(1));
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_out_valid", VW'(out_valid), VW'(0));
    chk("mid_rst_out_vec", out_vec_flat, '0);
    chk("mid_rst_imu_vec", imu_vec_flat, '0);
    chk("mid_rst_err", VW'(err_timeout), VW'(0));
    @(posedge clk); #1;
    chk("mid_rst_in_ready", VW'(in_ready), VW'(1));
    for (int i = 0; i < N; i++) v[i*W +: W] = rnd_elem();
    run_vec(v, 16'h3700, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
